grab_trigger_ctrl: RTL
======================

Name: grab_trigger_ctrl

Overview:
- RTL grab-trigger qualifier on the sensor-controller side.
- Receives the grab trigger stimulus produced by the validation environment (hardware trigger pin, software trigger pulse), qualifies it by programmed source and activation, and issues one grab-start request per accepted trigger to the exposure/readout sequencer.
- Counts accepted and dropped triggers for register readback.

Parameters:
- FILTER_W, 8, width of the hardware-trigger glitch-filter counter.
- CNT_W, 16, width of the accepted and dropped trigger counters.

Ports:
- sys_clk  in  1  single system clock.
- sys_reset_n  in  1  asynchronous active-low reset.
- grab_arm  in  1  pulse; arms the block (register GRAB_CMD).
- grab_abort  in  1  pulse; disarms and cancels any pending request.
- trig_src  in  3  1=IMMEDIATE, 2=HW_TRIG, 3=SW_TRIG, 4=SFNC; other values are reserved.
- trig_act  in  3  0=RISING, 1=FALLING, 2=ANY, 3=LEVEL_HI, 4=LEVEL_LO; other values are reserved.
- filter_len  in  FILTER_W  number of stable cycles required on hw_trig_in; 0 means no filter.
- hw_trig_in  in  1  asynchronous trigger pin.
- sw_trig  in  1  single-cycle software trigger pulse.
- grab_req  out  1  grab-start request.
- grab_ack  in  1  sequencer acceptance of grab_req.
- grab_done  in  1  pulse; end of readout for the current grab.
- armed  out  1  status; high while the block is not in IDLE.
- trig_cnt  out  CNT_W  accepted triggers.
- drop_cnt  out  CNT_W  triggers that arrived while BUSY or REQ.
- overrun  out  1  sticky; set on any drop, cleared by grab_arm.

Behaviour:
- Reset: grab_req=0, armed=0, trig_cnt=0, drop_cnt=0, overrun=0, FSM=IDLE, synchronizer and filter state cleared.
- Synchronizer: hw_trig_in passes through a 2-FF synchronizer.
- Filter:
  - The filtered level changes only after the synchronized value has differed from it for filter_len consecutive cycles.
  - When filter_len=0 the filtered level equals the synchronized value.
- Edge detection: rise/fall is derived by registering the filtered level. From the hw_trig_in transition to the internal event takes 3 cycles plus filter_len cycles.
- Trigger event (trig_ev), by source:
  - HW_TRIG: RISING=rise, FALLING=fall, ANY=rise|fall, LEVEL_HI=level==1, LEVEL_LO=level==0. Reserved trig_act gives no event.
  - SW_TRIG: sw_trig.
  - SFNC: sw_trig OR the HW_TRIG event.
  - IMMEDIATE: constant 1 (free-run).
  - Reserved trig_src: no event.
- FSM:
  - IDLE: grab_arm moves to ARMED. Triggers are ignored and not counted.
  - ARMED: trig_ev asserts grab_req on the next cycle, increments trig_cnt and moves to REQ.
  - REQ: grab_req stays high until the cycle grab_ack=1, then goes to BUSY with grab_req=0 on the following cycle. An edge or sw_trig event in REQ increments drop_cnt and sets overrun.
  - BUSY: grab_done returns to ARMED. Edge or sw_trig events increment drop_cnt and set overrun. Level and IMMEDIATE events are never counted as drops.
- Level and IMMEDIATE modes: after grab_done, a level still valid re-triggers from ARMED, at the earliest 1 cycle after returning.
- grab_abort: highest priority in any state. Next cycle: FSM=IDLE, grab_req=0. Counters are kept.
- Simultaneous events:
  - grab_arm in a non-IDLE state is ignored except for clearing overrun.
  - grab_ack and grab_done in the same cycle in REQ: go to BUSY; grab_done is ignored.
  - trig_ev in the same cycle as grab_done in BUSY counts as a drop.
- Counters saturate at all-ones; they do not wrap.
- trig_src and trig_act are sampled live. Changing them outside IDLE is legal; they take effect on the next event evaluation, and edge history is kept.
- armed=1 whenever the FSM is not in IDLE.

Decomposition:
- Shared package grab_trig_pkg holds:
  - the source and activation localparams with the same encodings as the validation core package;
  - the FSM state enum {IDLE, ARMED, REQ, BUSY}.
- Sub-module trig_sync_filter holds the 2-FF synchronizer, glitch-filter counter, and rise/fall/level outputs.

Test Plan:
- HW_TRIG/RISING, filter_len=4:
  - Pin high for 10 cycles gives grab_req at cycle 3+4+1 after the edge, trig_cnt=1.
  - A 3-cycle glitch produces no request.
- HW_TRIG/ANY: arm, then drive the pin with a 1-0-1 sequence with ack/done between each → 3 requests, trig_cnt=3.
- SW_TRIG: two sw_trig pulses, the second during BUSY → trig_cnt=1, drop_cnt=1, overrun=1; a following grab_arm clears overrun.
- HW_TRIG/LEVEL_HI: pin held high across 3 grab_done pulses → 4 requests; each re-arm issues grab_req 1 cycle after ARMED; drop_cnt=0.
- IMMEDIATE: grab_abort asserted during REQ → grab_req=0 next cycle, armed=0; subsequent grab_done is ignored.
- Reset mid-BUSY: assert sys_reset_n low asynchronously → all outputs 0 immediately. With CNT_W=4 and 20 drops, drop_cnt saturates at 15.

Source files
------------

// File: rtl/grab_trigger_ctrl_pkg.sv
// grab_trig_pkg: trigger source/activation encodings, FSM states and hardware-event decode
package grab_trig_pkg;
  localparam logic [2:0] SRC_IMMEDIATE = 3'd1;
  localparam logic [2:0] SRC_HW        = 3'd2;
  localparam logic [2:0] SRC_SW        = 3'd3;
  localparam logic [2:0] SRC_SFNC      = 3'd4;
  localparam logic [2:0] ACT_RISING    = 3'd0;
  localparam logic [2:0] ACT_FALLING   = 3'd1;
  localparam logic [2:0] ACT_ANY       = 3'd2;
  localparam logic [2:0] ACT_LEVEL_HI  = 3'd3;
  localparam logic [2:0] ACT_LEVEL_LO  = 3'd4;
  typedef enum logic [1:0] {IDLE, ARMED, REQ, BUSY} state_t;
  function automatic logic [1:0] hw_event(input logic [2:0] act, input logic rise, input logic fall, input logic level);
    return act == ACT_RISING   ? {rise, 1'b0} :
           act == ACT_FALLING  ? {fall, 1'b0} :
           act == ACT_ANY      ? {rise | fall, 1'b0} :
           act == ACT_LEVEL_HI ? {1'b0, level} :
           act == ACT_LEVEL_LO ? {1'b0, ~level} : 2'b00;
  endfunction
endpackage

// File: rtl/grab_trigger_ctrl_if.sv
// grab_trigger_ctrl_if: grab request/acknowledge/done handshake with the exposure sequencer
interface grab_trigger_ctrl_if;
  logic grab_req;
  logic grab_ack;
  logic grab_done;
  modport master (output grab_req, input grab_ack, input grab_done);
  modport slave (input grab_req, output grab_ack, output grab_done);
endinterface

// File: rtl/grab_trigger_ctrl_sync_filter.sv
// trig_sync_filter: 2-FF synchronizer, glitch filter and registered rise/fall/level of the trigger pin
module trig_sync_filter #(
  parameter int FILTER_W = 8
) (
  input  logic                sys_clk,
  input  logic                sys_reset_n,
  input  logic                hw_trig_in,
  input  logic [FILTER_W-1:0] filter_len,
  output logic                rise,
  output logic                fall,
  output logic                level
);
  logic s1, s2, flt, lvl, settle;
  logic [FILTER_W-1:0] cnt;
  assign lvl = filter_len == '0 ? s2 : flt;
  assign settle = filter_len == '0 || s2 == flt || cnt >= filter_len - 1'b1;
  always_ff @(posedge sys_clk or negedge sys_reset_n)
    if (!sys_reset_n) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      flt   <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      s1    <= hw_trig_in;
      s2    <= s1;
      flt   <= settle ? s2 : flt;
      cnt   <= settle ? '0 : cnt + 1'b1;
      level <= lvl;
      rise  <= lvl & ~level;
      fall  <= ~lvl & level;
    end
endmodule

// File: rtl/grab_trigger_ctrl.sv
// grab_trigger_ctrl: qualifies grab triggers by source/activation and issues one grab request per accepted trigger
module grab_trigger_ctrl
  import grab_trig_pkg::*;
#(
  parameter int FILTER_W = 8,
  parameter int CNT_W    = 16
) (
  input  logic                sys_clk,
  input  logic                sys_reset_n,
  input  logic                grab_arm,
  input  logic                grab_abort,
  input  logic [2:0]          trig_src,
  input  logic [2:0]          trig_act,
  input  logic [FILTER_W-1:0] filter_len,
  input  logic                hw_trig_in,
  input  logic                sw_trig,
  grab_trigger_ctrl_if.master seq,
  output logic                armed,
  output logic [CNT_W-1:0]    trig_cnt,
  output logic [CNT_W-1:0]    drop_cnt,
  output logic                overrun
);
  logic rise, fall, level, hw_edge, hw_lvl, use_hw, use_sw, edge_ev, trig_ev, acc, drop;
  state_t state, state_n;
  trig_sync_filter #(.FILTER_W(FILTER_W)) u_filter (
    .sys_clk    (sys_clk),
    .sys_reset_n(sys_reset_n),
    .hw_trig_in (hw_trig_in),
    .filter_len (filter_len),
    .rise       (rise),
    .fall       (fall),
    .level      (level)
  );
  assign {hw_edge, hw_lvl} = hw_event(trig_act, rise, fall, level);
  assign use_hw  = trig_src == SRC_HW || trig_src == SRC_SFNC;
  assign use_sw  = trig_src == SRC_SW || trig_src == SRC_SFNC;
  assign edge_ev = (use_hw & hw_edge) | (use_sw & sw_trig);
  assign trig_ev = edge_ev | (use_hw & hw_lvl) | (trig_src == SRC_IMMEDIATE);
  always_comb begin
    acc     = !grab_abort && state == ARMED && trig_ev;
    drop    = !grab_abort && (state == REQ || state == BUSY) && edge_ev;
    state_n = grab_abort ? IDLE :
              state == IDLE && grab_arm ? ARMED :
              acc ? REQ :
              state == REQ && seq.grab_ack ? BUSY :
              state == BUSY && seq.grab_done ? ARMED : state;
  end
  always_ff @(posedge sys_clk or negedge sys_reset_n)
    if (!sys_reset_n) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge sys_clk or negedge sys_reset_n)
    if (!sys_reset_n) begin
      trig_cnt <= '0;
      drop_cnt <= '0;
      overrun  <= 1'b0;
    end else begin
      trig_cnt <= trig_cnt + CNT_W'(acc && !(&trig_cnt));
      drop_cnt <= drop_cnt + CNT_W'(drop && !(&drop_cnt));
      overrun  <= drop | (overrun & ~grab_arm);
    end
  assign seq.grab_req = state == REQ;
  assign armed = state != IDLE;
endmodule
